// File: rtl/clm_inverse_sequencer_if.sv
// Multiplier handshake bundle between the inverse sequencer and a serial
// CLM multiplier: operands, issue strobe, product and completion level.
interface clm_inverse_sequencer_if #(
  parameter int W = 12
);
  logic [W-1:0] mul_p1;
  logic [W-1:0] mul_p2;
  logic         mul_drdy_i;
  logic [W-1:0] mul_out;
  logic         mul_drdy_o;

  modport master (
    output mul_p1,
    output mul_p2,
    output mul_drdy_i,
    input  mul_out,
    input  mul_drdy_o
  );

  modport slave (
    input  mul_p1,
    input  mul_p2,
    input  mul_drdy_i,
    output mul_out,
    output mul_drdy_o
  );
endinterface

// File: rtl/clm_inverse_sequencer.sv
// Sequences an 11-step addition chain on a shared CLM multiplier to form a^254.
// Optional watchdog with ERR state: define CLM_INV_WATCHDOG_EN.
module clm_inverse_sequencer #(
  parameter  int d = 4,
  localparam int W = 8 + d
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  clm_inverse_sequencer_if.master mul
`ifdef CLM_INV_WATCHDOG_EN
  ,
  output logic         err
`endif
);

`ifdef CLM_INV_WATCHDOG_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR
  } state_e;
  localparam int WD_LIM = 2 * (9 + d);
  localparam int WCW = $clog2(WD_LIM + 1);
  logic [WCW-1:0] wcnt_q, wcnt_d;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } state_e;
`endif

  state_e state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] x2_q, x2_d;
  logic [W-1:0] x3_q, x3_d;
  logic [W-1:0] x12_q, x12_d;
  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] res_q, res_d;
  logic blank_q, blank_d;
  logic [W-1:0] op_a, op_b;
  logic cap;

  always_comb begin
    op_a = cur_q;
    op_b = x2_q;
    unique case (1'b1)
      (k_q == 4'd0): begin op_a = x_q;   op_b = x_q;   end
      (k_q == 4'd1): begin op_a = x2_q;  op_b = x_q;   end
      (k_q == 4'd2): begin op_a = x3_q;  op_b = x3_q;  end
      (k_q == 4'd4): begin op_a = x12_q; op_b = x3_q;  end
      (k_q == 4'd9): begin op_a = cur_q; op_b = x12_q; end
      (k_q == 4'd3),
      (k_q >= 4'd5 && k_q <= 4'd8): begin
        op_a = cur_q;
        op_b = cur_q;
      end
      default: begin op_a = cur_q; op_b = x2_q; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    k_d = k_q;
    x_d = x_q;
    x2_d = x2_q;
    x3_d = x3_q;
    x12_d = x12_q;
    cur_d = cur_q;
    res_d = res_q;
    blank_d = blank_q;
    cap = 1'b0;
    mul.mul_p1 = '0;
    mul.mul_p2 = '0;
    mul.mul_drdy_i = 1'b0;
`ifdef CLM_INV_WATCHDOG_EN
    wcnt_d = wcnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d = a_in;
          k_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul.mul_drdy_i = 1'b1;
        mul.mul_p1 = op_a;
        mul.mul_p2 = op_b;
        blank_d = 1'b1;
        state_d = S_WAIT;
`ifdef CLM_INV_WATCHDOG_EN
        wcnt_d = '0;
`endif
      end
      S_WAIT: begin
        mul.mul_p1 = op_a;
        mul.mul_p2 = op_b;
        blank_d = 1'b0;
        // completion level is stale in the first WAIT cycle
        cap = !blank_q && mul.mul_drdy_o;
        if (cap) begin
          if (k_q == 4'd10) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q + 4'd1;
            state_d = S_ISSUE;
          end
`ifdef CLM_INV_WATCHDOG_EN
        end else if (wcnt_q == WCW'(WD_LIM - 1)) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef CLM_INV_WATCHDOG_EN
      S_ERR: state_d = S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
    if (cap) begin
      unique case (1'b1)
        (k_q == 4'd0):  x2_d = mul.mul_out;
        (k_q == 4'd1):  x3_d = mul.mul_out;
        (k_q == 4'd3):  x12_d = mul.mul_out;
        (k_q == 4'd10): res_d = mul.mul_out;
        default:        cur_d = mul.mul_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q <= '0;
      x_q <= '0;
      x2_q <= '0;
      x3_q <= '0;
      x12_q <= '0;
      cur_q <= '0;
      res_q <= '0;
      blank_q <= 1'b0;
`ifdef CLM_INV_WATCHDOG_EN
      wcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      x_q <= x_d;
      x2_q <= x2_d;
      x3_q <= x3_d;
      x12_q <= x12_d;
      cur_q <= cur_d;
      res_q <= res_d;
      blank_q <= blank_d;
`ifdef CLM_INV_WATCHDOG_EN
      wcnt_q <= wcnt_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign result = res_q;
`ifdef CLM_INV_WATCHDOG_EN
  assign err = (state_q == S_ERR);
`endif

endmodule

// File: tb/tb_clm_inverse_sequencer.sv
// Bench for clm_inverse_sequencer: GF(2^8) multiplier model plus
// power-based reference for operands, timing and a^254.
module tb_clm_inverse_sequencer;
  localparam int D = 4;
  localparam int W = 8 + D;
  localparam int PER = 10 + D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic busy, done;
  logic [W-1:0] result;
`ifdef CLM_INV_WATCHDOG_EN
  logic err;
`endif

  clm_inverse_sequencer_if #(.W(W)) mif ();

  clm_inverse_sequencer #(.d(D)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a_in(a_in),
    .busy(busy),
    .done(done),
    .result(result),
    .mul(mif.master)
`ifdef CLM_INV_WATCHDOG_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_pow(logic [7:0] a, int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = gf_mul(r, a);
    return r;
  endfunction

  // behavioural serial multiplier: product valid 9+D cycles after issue
  logic mute = 1'b0;
  int mcnt;
  logic [7:0] mprod;
  always @(posedge clk) begin
    if (rst) begin
      mif.mul_drdy_o <= 1'b0;
      mif.mul_out <= '0;
      mcnt <= 0;
    end else if (mif.mul_drdy_i) begin
      mif.mul_drdy_o <= 1'b0;
      mcnt <= 9 + D - 1;
      mprod <= gf_mul(mif.mul_p1[7:0], mif.mul_p2[7:0]);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !mute) begin
        mif.mul_drdy_o <= 1'b1;
        mif.mul_out <= {{D{1'b0}}, mprod};
      end
    end
  end

  int iss_cyc[$];
  logic [W-1:0] iss_p1[$];
  logic [W-1:0] iss_p2[$];
  int width_err = 0;
  int stab_err = 0;
  logic mon_en = 1'b1;
  logic prev_i = 1'b0;
  logic [W-1:0] hold1 = '0;
  logic [W-1:0] hold2 = '0;

  always @(negedge clk) begin
    if (mif.mul_drdy_i) begin
      iss_cyc.push_back(cyc);
      iss_p1.push_back(mif.mul_p1);
      iss_p2.push_back(mif.mul_p2);
      hold1 = mif.mul_p1;
      hold2 = mif.mul_p2;
      if (prev_i) width_err++;
    end else if (mon_en && busy && !done && !rst) begin
      if (mif.mul_p1 !== hold1 || mif.mul_p2 !== hold2) stab_err++;
    end
    prev_i = mif.mul_drdy_i;
  end

  int E1[11] = '{1, 2, 3, 6, 12, 15, 30, 60, 120, 240, 252};
  int E2[11] = '{1, 1, 3, 6, 3, 15, 30, 60, 120, 12, 2};

  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_q();
    iss_cyc.delete();
    iss_p1.delete();
    iss_p2.delete();
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    dc = done ? cyc : -1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".drdy_i"}, 32'(mif.mul_drdy_i), 0);
    chk({tag, ".result"}, 32'(result), 0);
    chk({tag, ".p1"}, 32'(mif.mul_p1), 0);
    chk({tag, ".p2"}, 32'(mif.mul_p2), 0);
  endtask

  task automatic run(input logic [7:0] a, input string tag);
    int c0, dc, ops_err;
    clear_q();
    start = 1'b1;
    a_in = {{D{1'b0}}, a};
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done(dc);
    chk({tag, ".done_cyc"}, 32'(dc - c0), 155);
    chk({tag, ".result"}, 32'(result), 32'(gf_pow(a, 254)));
    chk({tag, ".issues"}, 32'(iss_cyc.size()), 11);
    ops_err = 0;
    for (int k = 0; k < 11 && k < iss_cyc.size(); k++) begin
      if (iss_cyc[k] != c0 + 1 + k * PER) ops_err++;
      if (iss_p1[k] !== W'(gf_pow(a, E1[k]))) ops_err++;
      if (iss_p2[k] !== W'(gf_pow(a, E2[k]))) ops_err++;
    end
    chk({tag, ".schedule"}, 32'(ops_err), 0);
    @(negedge clk);
    chk({tag, ".idle_after"}, {30'd0, busy, done}, 0);
  endtask

  initial begin
    int c0, dc, dc2;
    logic [7:0] a1, a2;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run(8'h02, "a02");
    run(8'h53, "a53");
    run(8'h01, "a01");
    run(8'h00, "a00");
    for (int i = 0; i < 3; i++) run(8'($urandom_range(1, 255)), "rand");

    // start held high: back-to-back runs, mid-run edges ignored
    a1 = 8'($urandom_range(1, 255));
    a2 = 8'($urandom_range(1, 255));
    start = 1'b1;
    a_in = {{D{1'b0}}, a1};
    c0 = cyc;
    repeat (20) @(negedge clk);
    a_in = {{D{1'b0}}, a2};
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_done(dc);
    chk("held.done1_cyc", 32'(dc - c0), 155);
    chk("held.result1", 32'(result), 32'(gf_pow(a1, 254)));
    @(negedge clk);
    @(negedge clk);
    chk("held.restart_busy", 32'(busy), 1);
    start = 1'b0;
    wait_done(dc2);
    chk("held.done2_cyc", 32'(dc2 - c0), 311);
    chk("held.result2", 32'(result), 32'(gf_pow(a2, 254)));
    @(negedge clk);
    chk("held.idle", 32'(busy), 0);

    // reset during WAIT of step 5
    clear_q();
    start = 1'b1;
    a_in = {{D{1'b0}}, 8'($urandom_range(1, 255))};
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 75) @(negedge clk);
    chk("midrst.step5_issued", 32'(iss_cyc.size()), 6);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    run(8'($urandom_range(1, 255)), "postrst");

`ifdef CLM_INV_WATCHDOG_EN
    begin
      logic saw_done;
      mute = 1'b1;
      mon_en = 1'b0;
      start = 1'b1;
      a_in = 12'h0A7;
      c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + 27) @(negedge clk);
      chk("wd.err_before", 32'(err), 0);
      @(negedge clk);
      chk("wd.err_after", 32'(err), 1);
      chk("wd.busy", 32'(busy), 1);
      saw_done = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
      end
      chk("wd.no_done", 32'(saw_done), 0);
      chk("wd.err_held", 32'(err), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("wd.err_cleared", 32'(err), 0);
      rst = 1'b0;
      mute = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
    end
`endif

    chk("strobe_width", 32'(width_err), 0);
    chk("operand_stable", 32'(stab_err), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
